mips_regfile_mp: RTL and testbench
==================================

# mips_regfile_mp

Parametrised multi-port MIPS general-purpose register file for the ID stage. It provides N combinational read ports and M write ports with same-cycle write-to-read bypass and a hardwired zero register. A per-register busy scoreboard marks registers with pending writes from long-latency producers (loads, mul/div). A post-reset clear sequencer zeroes all storage, so no memory-init file is needed.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
- NUM_RD, 2, read ports
- NUM_WR, 1, write ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  read register has a pending write
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*ADDR_W  write indices
- wr_data  in  NUM_WR*DATA_W  write data
- bsy_set  in  1  mark bsy_addr pending
- bsy_addr  in  ADDR_W  register to mark
- init_done  out  1  clear sequence finished; file usable

## Operation
- States: INIT, RUN. rst forces INIT and sets the clear counter to 0 from any state, including mid-operation.
- INIT:
  - Writes 0 to entry[cnt] each cycle, cnt = 0..DEPTH-1.
  - After the write of DEPTH-1, moves to RUN.
  - wr_en and bsy_set are ignored. rd_data = 0, rd_busy = 0, init_done = 0.
- RUN:
  - init_done = 1.
  - Each enabled write port updates entry[wr_addr] on posedge.
  - When several ports target the same address, the highest port index wins.
- Read port k:
  - If ZERO_REG and rd_addr == 0: data 0, busy 0.
  - Otherwise, if any enabled write port matches rd_addr, output the winning port's wr_data (bypass).
  - Otherwise, output entry[rd_addr].
- Scoreboard, one bit per register, all cleared on rst:
  - An enabled write to address a clears busy[a].
  - bsy_set sets busy[bsy_addr].
  - Set and clear on the same register in the same cycle: set wins (a new producer supersedes the old one).
  - bsy_set to register 0 is ignored when ZERO_REG = 1.
- rd_busy[k]:
  - Equals busy[rd_addr].
  - Forced 0 when an enabled write to rd_addr is bypassed this cycle.
  - This bypass applies even if bsy_set targets the same register this cycle; the new busy bit becomes visible next cycle.
- ZERO_REG = 1: writes to register 0 are dropped, while still participating in priority.

## Timing
- Reset values: init_done = 0; busy = 0; rd_data = 0 and rd_busy = 0 while rst or INIT.
- Clear latency: rst high in cycle C0, low from C1. The INIT writes occupy C1..C1+DEPTH-1. init_done = 1 from C1+DEPTH (32 cycles for the default configuration).
- Read latency: 0 cycles (combinational from rd_addr / wr_*).
- Write latency: visible through bypass the same cycle, from storage the next cycle.
- Scoreboard latency: bsy_set at cycle t shows as rd_busy at t+1.
- rst while writes are pending: the writes are discarded; INIT restarts from entry 0.

## Structure
- Package mips_regfile_pkg holds:
  - Defaults DATA_W_DEF = 32, ADDR_W_DEF = 5.
  - Enum rf_state_e {RF_INIT, RF_RUN}.
  - Function wr_winner(), which returns the highest-index matching write port.
- Sub-module mips_rf_scoreboard (busy vector, set/clear priority, per-port rd_busy lookup) with the same DATA_W-free parameter set.
- Storage is a flat reg array. Do not use $readmemh.

## Test plan
- Reset, then idle: init_done low for exactly 32 cycles after rst drops. Every address then reads 0x00000000.
- wr_en = 1, wr_addr = 5, wr_data = 0xDEADBEEF, with rd_addr0 = 5 in the same cycle: rd_data0 = 0xDEADBEEF that cycle and the next (storage path).
- NUM_WR = 2, both ports write register 9 with 0x11 and 0x22: the bypass shows 0x22 and storage holds 0x22. A write to register 0 with 0xFFFFFFFF still reads 0.
- bsy_set on register 12 at t: rd_busy for register 12 is 1 at t+1. A write to 12 with 0x55 at t+3: rd_busy is 0 at t+3 with data 0x55. A simultaneous bsy_set and write on 12: busy stays 1.
- rst asserted for 1 cycle while the file is populated and busy bits are set: busy clears, init_done drops, and after 32 cycles all registers read 0.
- Writes issued during INIT (wr_en = 1, addr 3, 0xAB): ignored; register 3 reads 0 after init_done.

Source files
------------

// File: rtl/mips_regfile_pkg.sv
// Shared types and helpers for the multi-port MIPS register file.
package mips_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int MAX_WR     = 4;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Highest-index port whose match bit is set; callers gate on |hit.
  function automatic logic [1:0] wr_winner(input logic [MAX_WR-1:0] hit);
    logic [1:0] idx;
    idx = '0;
    for (int p = 0; p < MAX_WR; p++) begin
      if (hit[p]) idx = 2'(p);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mips_regfile_mp_if.sv
// Read/write/scoreboard bus of the register file; master drives, slave is the file.
interface mips_regfile_mp_if
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     bsy_set;
  logic [ADDR_W-1:0]        bsy_addr;
  logic                     init_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, bsy_set, bsy_addr,
    input  rd_data, rd_busy, init_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, bsy_set, bsy_addr,
    output rd_data, rd_busy, init_done
  );
endinterface

// File: rtl/mips_rf_scoreboard.sv
// Per-register pending-write bits with set-over-clear priority and per-port lookup.
module mips_rf_scoreboard
  import mips_regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     bsy_set,
  input  logic [ADDR_W-1:0]        bsy_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy, busy_nxt;

  // Clears first so a same-cycle set from a new producer overrides them.
  always_comb begin
    busy_nxt = busy;
    if (run) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p]) busy_nxt[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (bsy_set && !((ZERO_REG != 0) && (bsy_addr == '0)))
        busy_nxt[bsy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      byp = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ra)) byp = 1'b1;
      end
    end

    assign rd_busy[k] = run && !byp && !((ZERO_REG != 0) && (ra == '0)) && busy[ra];
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port GPR file: post-reset clear sequencer, bypassed reads, busy scoreboard.
module mips_regfile_mp
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input logic              clk,
  input logic              rst,
  mips_regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              run;
  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] wdat [MAX_WR];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RF_INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (&cnt) state_nxt = RF_RUN;
      end
      default: ;
    endcase
  end

  // A reset cycle counts as not running so pending writes never land.
  assign run           = (state == RF_RUN) && !rst;
  assign bus.init_done = run;

  // Ascending port loop: the last nonblocking write, the highest port, wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RF_INIT) begin
        mem[cnt] <= '0;
      end else begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (bus.wr_en[p] &&
              !((ZERO_REG != 0) && (bus.wr_addr[p*ADDR_W +: ADDR_W] == '0)))
            mem[bus.wr_addr[p*ADDR_W +: ADDR_W]] <= bus.wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar p = 0; p < MAX_WR; p++) begin : g_wdat
    if (p < NUM_WR) begin : g_on
      assign wdat[p] = bus.wr_data[p*DATA_W +: DATA_W];
    end else begin : g_off
      assign wdat[p] = '0;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [MAX_WR-1:0] hit;
    logic [1:0]        win;
    logic [DATA_W-1:0] rdat;

    assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      hit = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        hit[p] = bus.wr_en[p] && (bus.wr_addr[p*ADDR_W +: ADDR_W] == ra);
      end
    end

    assign win = wr_winner(hit);

    always_comb begin
      if (!run || ((ZERO_REG != 0) && (ra == '0))) rdat = '0;
      else if (|hit)                               rdat = wdat[win];
      else                                         rdat = mem[ra];
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = rdat;
  end

  mips_rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .bsy_set  (bus.bsy_set),
    .bsy_addr (bus.bsy_addr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (bus.rd_busy)
  );

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Randomized bench for mips_regfile_mp against an array-based reference model.
module tb_mips_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  mips_regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  int            m_since;
  bit            m_run;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    bus.rd_addr[k*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en[p]             = en;
    bus.wr_addr[p*AW +: AW]  = a;
    bus.wr_data[p*DW +: DW]  = d;
  endtask

  task automatic idle_inputs();
    bus.wr_en    = '0;
    bus.bsy_set  = 1'b0;
    bus.bsy_addr = '0;
  endtask

  // Reference read: zero register, then highest matching write port, then storage.
  task automatic exp_port(input int k, output logic [DW-1:0] d, output bit b);
    int a;
    bit found;
    a = int'(bus.rd_addr[k*AW +: AW]);
    d = '0;
    b = 1'b0;
    found = 1'b0;
    if (m_run && !rst && a != 0) begin
      for (int p = NW - 1; p >= 0; p--) begin
        if (!found && bus.wr_en[p] && int'(bus.wr_addr[p*AW +: AW]) == a) begin
          found = 1'b1;
          d = bus.wr_data[p*DW +: DW];
        end
      end
      if (!found) begin
        d = m_mem[a];
        b = m_busy[a];
      end
    end
  endtask

  task automatic model_commit();
    int a;
    if (rst) begin
      m_run   = 1'b0;
      m_since = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else if (!m_run) begin
      m_since++;
      if (m_since == DEPTH) m_run = 1'b1;
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (bus.wr_en[p]) begin
          a = int'(bus.wr_addr[p*AW +: AW]);
          if (a != 0) m_mem[a] = bus.wr_data[p*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (bus.bsy_set && bus.bsy_addr != '0) m_busy[int'(bus.bsy_addr)] = 1'b1;
    end
  endtask

  task automatic cycle(input string tag);
    logic [DW-1:0] d;
    bit            b;
    @(negedge clk);
    check_val($sformatf("%s.init_done", tag), 64'(bus.init_done), 64'(m_run && !rst));
    for (int k = 0; k < NR; k++) begin
      exp_port(k, d, b);
      check_val($sformatf("%s.rd_data%0d", tag, k), 64'(bus.rd_data[k*DW +: DW]), 64'(d));
      check_val($sformatf("%s.rd_busy%0d", tag, k), 64'(bus.rd_busy[k]), 64'(b));
    end
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    idle_inputs();
    m_run   = 1'b0;
    m_since = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    cycle("rst");

    // Clear sequence with writes and busy marks that must be ignored.
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      set_wr(0, 1'b1, 5'd3, 32'hAB);
      bus.bsy_set  = 1'b1;
      bus.bsy_addr = 5'd3;
      set_rd(0, 5'd3);
      set_rd(1, 5'(i));
      #1 check_val("init_low", 64'(bus.init_done), 64'd0);
      cycle("init");
    end
    idle_inputs();
    #1 check_val("init_done_at_32", 64'(bus.init_done), 64'd1);

    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(DEPTH - 1 - a));
      #1 check_val("clear_zero", 64'(bus.rd_data[0 +: DW]), 64'd0);
      cycle("clear");
    end

    // Single write with same-cycle bypass, then storage path.
    idle_inputs();
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    set_rd(0, 5'd5);
    #1 check_val("byp_w5", 64'(bus.rd_data[0 +: DW]), 64'hDEADBEEF);
    cycle("w5");
    idle_inputs();
    #1 check_val("stor_w5", 64'(bus.rd_data[0 +: DW]), 64'hDEADBEEF);
    cycle("w5b");

    // Two ports collide on register 9: port 1 wins.
    set_wr(0, 1'b1, 5'd9, 32'h11);
    set_wr(1, 1'b1, 5'd9, 32'h22);
    set_rd(0, 5'd9);
    #1 check_val("byp_w9", 64'(bus.rd_data[0 +: DW]), 64'h22);
    cycle("w9");
    idle_inputs();
    #1 check_val("stor_w9", 64'(bus.rd_data[0 +: DW]), 64'h22);
    cycle("w9b");

    set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(0, 5'd0);
    #1 check_val("byp_r0", 64'(bus.rd_data[0 +: DW]), 64'd0);
    cycle("r0");
    idle_inputs();
    #1 check_val("stor_r0", 64'(bus.rd_data[0 +: DW]), 64'd0);
    cycle("r0b");

    // Scoreboard on register 12.
    bus.bsy_set  = 1'b1;
    bus.bsy_addr = 5'd12;
    set_rd(1, 5'd12);
    #1 check_val("busy12_t", 64'(bus.rd_busy[1]), 64'd0);
    cycle("b12_t");
    idle_inputs();
    #1 check_val("busy12_t1", 64'(bus.rd_busy[1]), 64'd1);
    cycle("b12_t1");
    cycle("b12_t2");
    set_wr(0, 1'b1, 5'd12, 32'h55);
    #1 check_val("busy12_wr", 64'(bus.rd_busy[1]), 64'd0);
    check_val("data12_wr", 64'(bus.rd_data[DW +: DW]), 64'h55);
    cycle("b12_t3");
    idle_inputs();
    #1 check_val("busy12_clr", 64'(bus.rd_busy[1]), 64'd0);
    cycle("b12_t4");
    bus.bsy_set  = 1'b1;
    bus.bsy_addr = 5'd12;
    set_wr(1, 1'b1, 5'd12, 32'h66);
    #1 check_val("busy12_setwr_byp", 64'(bus.rd_busy[1]), 64'd0);
    cycle("b12_t5");
    idle_inputs();
    #1 check_val("busy12_set_wins", 64'(bus.rd_busy[1]), 64'd1);
    check_val("data12_setwr", 64'(bus.rd_data[DW +: DW]), 64'h66);
    cycle("b12_t6");

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int p = 0; p < NW; p++)
        set_wr(p, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31)),
               $urandom);
      bus.bsy_set  = ($urandom_range(0, 3) == 0);
      bus.bsy_addr = 5'($urandom_range(0, 7));
      for (int k = 0; k < NR; k++)
        set_rd(k, 5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31)));
      cycle("rnd");
    end
    rst = 1'b0;
    idle_inputs();
    for (int n = 0; n < DEPTH + 2; n++) cycle("settle");

    // Populate, mark busy, then reset with a write pending.
    set_wr(0, 1'b1, 5'd7, 32'h1234);
    set_wr(1, 1'b1, 5'd8, 32'h5678);
    bus.bsy_set  = 1'b1;
    bus.bsy_addr = 5'd8;
    cycle("pop");
    idle_inputs();
    bus.bsy_set  = 1'b1;
    bus.bsy_addr = 5'd7;
    cycle("pop2");
    idle_inputs();
    set_rd(0, 5'd7);
    set_rd(1, 5'd8);
    #1 check_val("pre_rst_busy", 64'(bus.rd_busy[0]), 64'd1);
    cycle("pop3");
    rst = 1'b1;
    set_wr(0, 1'b1, 5'd4, 32'hCAFE);
    #1 check_val("rst_init_done", 64'(bus.init_done), 64'd0);
    check_val("rst_busy", 64'(bus.rd_busy[0]), 64'd0);
    cycle("rst2");
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      set_wr(0, 1'b1, 5'd3, 32'hAB);
      #1 check_val("reinit_low", 64'(bus.init_done), 64'd0);
      cycle("reinit");
    end
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(a));
      #1 check_val("reclear_data", 64'(bus.rd_data[0 +: DW]), 64'd0);
      check_val("reclear_busy", 64'(bus.rd_busy[1]), 64'd0);
      cycle("reclear");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
